// File: rtl/max_pool_2x2_stream.sv
// Streaming 2x2/stride-2 max-pool over a raster-order valid/ready pixel stream.
// Optional build macro RELU_FUSE_EN clamps negative input pixels to 0 before pooling.
`timescale 1ns/1ps
module max_pool_2x2_stream #(
  parameter int IMG_W  = 32,
  parameter int IMG_H  = 32,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_data,
  output logic                     out_last,
  output logic                     frame_done
);
  localparam int CW  = $clog2(IMG_W);
  localparam int RW  = $clog2(IMG_H);
  localparam int HW  = IMG_W / 2;
  localparam int HCW = (HW > 1) ? $clog2(HW) : 1;

  logic [CW-1:0]            col;
  logic [RW-1:0]            row;
  logic [HCW-1:0]           hidx;
  logic signed [DATA_W-1:0] pair, pix, hmax, vmax, lbuf_rd;
  logic signed [DATA_W-1:0] lbuf [HW];
  logic                     in_xfer, out_xfer, col_end, row_end;

  function automatic logic signed [DATA_W-1:0] smax(input logic signed [DATA_W-1:0] a,
                                                    input logic signed [DATA_W-1:0] b);
    return (a >= b) ? a : b;
  endfunction

  always_comb begin
`ifdef RELU_FUSE_EN
    pix = in_data[DATA_W-1] ? '0 : in_data;
`else
    pix = in_data;
`endif
  end

  assign in_ready = !out_valid || out_ready;
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;
  assign col_end  = (col == CW'(IMG_W - 1));
  assign row_end  = (row == RW'(IMG_H - 1));
  assign hidx     = HCW'(col >> 1);
  assign lbuf_rd  = lbuf[hidx];
  assign hmax     = smax(pair, pix);
  assign vmax     = smax(lbuf_rd, hmax);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col        <= '0;
      row        <= '0;
      pair       <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_last   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= out_xfer && out_last;
      if (clr) begin
        // abort wins over any same-cycle input; a pending pooled pixel is dropped
        col       <= '0;
        row       <= '0;
        pair      <= '0;
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end else begin
        if (out_xfer) out_valid <= 1'b0;
        if (in_xfer) begin
          if (!col[0]) pair <= pix;
          if (col[0] && row[0]) begin
            out_data  <= vmax;
            out_last  <= col_end && row_end;
            out_valid <= 1'b1;
          end
          col <= col_end ? '0 : col + 1'b1;
          if (col_end) row <= row_end ? '0 : row + 1'b1;
        end
      end
    end
  end

  // even rows park horizontal-pair maxima; odd rows always read them back first
  always_ff @(posedge clk) begin
    if (in_xfer && !clr && col[0] && !row[0]) lbuf[hidx] <= hmax;
  end

endmodule

// File: tb/tb_max_pool_2x2_stream.sv
// Scoreboard bench: full-frame reference model feeds an expected queue; a monitor pops on each output beat.
`timescale 1ns/1ps
module tb_max_pool_2x2_stream;
  localparam int W = 4, H = 4, BW = 32, BH = 32, DW = 32;

  logic clk = 1'b0, rst = 1'b1, clr = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic in_ready, out_valid, out_last, frame_done;
  logic signed [DW-1:0] in_data = '0, out_data;
  logic b_clr = 1'b0, b_in_valid = 1'b0, b_out_ready = 1'b1;
  logic b_in_ready, b_out_valid, b_out_last, b_frame_done;
  logic signed [DW-1:0] b_in_data = '0, b_out_data;

  max_pool_2x2_stream #(.IMG_W(W), .IMG_H(H), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .frame_done(frame_done));

  max_pool_2x2_stream #(.IMG_W(BW), .IMG_H(BH), .DATA_W(DW)) dut_b (
    .clk(clk), .rst(rst), .clr(b_clr), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data), .out_last(b_out_last), .frame_done(b_frame_done));

  always #5 clk = ~clk;

  int nchk = 0, nfail = 0, cyc = 0, load_cyc = -1, rdy_mode = 1;
  int mr = 0, mc = 0, nout = 0, b_nout = 0;
  logic [DW-1:0] load_d;
  logic [DW:0] q[$], bq[$];
  int log_d[$];
  bit log_l[$];
  int b_lastpos[$];
  int ramp_exp[4] = '{5, 7, 13, 15};
  logic signed [DW-1:0] mpix [H][W];
  logic signed [DW-1:0] bpix [BH][BW];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic signed [DW-1:0] relu(input logic signed [DW-1:0] d);
`ifdef RELU_FUSE_EN
    return (d < 0) ? '0 : d;
`else
    return d;
`endif
  endfunction

  function automatic logic signed [DW-1:0] max4(input logic signed [DW-1:0] a, b, c, d);
    logic signed [DW-1:0] m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  function automatic logic signed [DW-1:0] rnd_pix();
    case ($urandom_range(0, 3))
      0: return $urandom;
      1: return $signed(32'($urandom_range(0, 40))) - 20;
      2: return ($urandom_range(0, 1) == 1) ? 32'sh7fffffff : 32'sh80000000;
      default: return $signed(32'($urandom_range(0, 2000))) - 1000;
    endcase
  endfunction

  // reference: store the whole frame, emit max of each completed 2x2 window
  task automatic model_push(input logic signed [DW-1:0] d);
    logic signed [DW-1:0] m;
    mpix[mr][mc] = relu(d);
    if (mr % 2 == 1 && mc % 2 == 1) begin
      m = max4(mpix[mr-1][mc-1], mpix[mr-1][mc], mpix[mr][mc-1], mpix[mr][mc]);
      q.push_back({(mr == H-1 && mc == W-1), m});
      load_cyc = cyc + 1;
      load_d   = m;
    end
    if (mc == W-1) begin mc = 0; mr = (mr == H-1) ? 0 : mr + 1; end
    else mc++;
  endtask

  task automatic model_reset();
    mr = 0; mc = 0; q.delete();
  endtask

  // called at posedge+1; returns at posedge+1 after the transfer edge
  task automatic send(input logic signed [DW-1:0] d);
    int t;
    bit done;
    t = 0; done = 0;
    in_valid = 1'b1; in_data = d;
    while (!done) begin
      @(negedge clk);
      if (in_ready && !clr && !rst) begin
        model_push(d);
        done = 1;
      end else if (++t > 300) begin
        nchk++; nfail++;
        $display("FAIL send_timeout: in_ready stuck at %0b, required 1", in_ready);
        done = 1;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic send_ramp(input int first, input int count);
    for (int i = first; i < first + count; i++) send(i);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (q.size() != 0 && t < 300) begin @(posedge clk); t++; end
    if (q.size() != 0) begin
      nchk++; nfail++;
      $display("FAIL drain_timeout: %0d pooled pixels outstanding, required 0", q.size());
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_ramp(input string nm);
    check({nm, "_count"}, log_d.size(), 4);
    for (int i = 0; i < 4 && i < log_d.size(); i++) begin
      check(nm, log_d[i], ramp_exp[i]);
      check({nm, "_last"}, 32'(log_l[i]), 32'(i == 3));
    end
  endtask

  always @(posedge clk) begin
    #2;
    case (rdy_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  bit exp_fd = 0, hold_arm = 0, hold_l = 0;
  logic [DW-1:0] hold_d = '0;
  always @(negedge clk) begin : mon
    logic [DW:0] e;
    if (rst) begin
      exp_fd = 0; hold_arm = 0;
    end else begin
      check("in_ready", 32'(in_ready), 32'(!out_valid || out_ready));
      check("frame_done", 32'(frame_done), 32'(exp_fd));
      if (hold_arm) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_data", out_data, hold_d);
        check("hold_last", 32'(out_last), 32'(hold_l));
      end
      if (cyc == load_cyc) begin
        check("latency_valid", 32'(out_valid), 32'd1);
        check("latency_data", out_data, load_d);
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          nchk++; nfail++;
          $display("FAIL unexpected_output: got %0h, required no output", out_data);
        end else begin
          e = q.pop_front();
          check("out_data", out_data, e[DW-1:0]);
          check("out_last", 32'(out_last), 32'(e[DW]));
        end
        log_d.push_back(int'(out_data));
        log_l.push_back(out_last);
        nout++;
      end
      exp_fd   = out_valid && out_ready && out_last;
      hold_arm = out_valid && !out_ready && !clr;
      hold_d   = out_data;
      hold_l   = out_last;
      if (b_out_valid && b_out_ready) begin
        b_nout++;
        if (bq.size() == 0) begin
          nchk++; nfail++;
          $display("FAIL b_unexpected_output: got %0h, required no output", b_out_data);
        end else begin
          e = bq.pop_front();
          check("b_out_data", b_out_data, e[DW-1:0]);
          check("b_out_last", 32'(b_out_last), 32'(e[DW]));
        end
        if (b_out_last) b_lastpos.push_back(b_nout);
      end
    end
  end

  initial begin
    #1000000;
    nchk++; nfail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end

  initial begin
    logic signed [DW-1:0] d;
    int bmr, bmc;
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_b_out_valid", 32'(b_out_valid), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;

    // ramp
    log_d.delete(); log_l.delete();
    send_ramp(0, 16); drain();
    check_ramp("ramp");

    // signed window in the top-left corner
    log_d.delete(); log_l.delete();
    for (int i = 0; i < 16; i++) begin
      case (i)
        0: d = -8;   1: d = -3;   4: d = -100;   5: d = -2;
        default: d = rnd_pix();
      endcase
      send(d);
    end
    drain();
`ifdef RELU_FUSE_EN
    check("signed_win", log_d[0], 32'd0);
`else
    check("signed_win", log_d[0], 32'hfffffffe);
`endif

    // backpressure after the first pooled pixel
    log_d.delete(); log_l.delete();
    send_ramp(0, 6);
    rdy_mode = 0;
    fork
      send_ramp(6, 10);
      begin
        repeat (3) @(negedge clk);
        check("bp_valid", 32'(out_valid), 32'd1);
        check("bp_data", out_data, 32'd5);
        check("bp_in_ready", 32'(in_ready), 32'd0);
        repeat (7) @(posedge clk);
        #1 rdy_mode = 1;
      end
    join
    drain();
    check_ramp("backpressure");

    // abort after 9 pixels; clr coincides with an offered pixel that must be discarded
    send_ramp(0, 9); drain();
    clr = 1'b1; in_valid = 1'b1; in_data = 99;
    @(posedge clk); #1 clr = 1'b0; in_valid = 1'b0;
    model_reset();
    log_d.delete(); log_l.delete();
    send_ramp(0, 16); drain();
    check_ramp("abort");

    // clr drops a stalled pooled pixel
    rdy_mode = 0;
    send_ramp(0, 6);
    @(posedge clk); #1 clr = 1'b1;
    @(posedge clk); #1 clr = 1'b0;
    model_reset();
    @(negedge clk);
    check("clr_drop_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1 rdy_mode = 1;
    log_d.delete(); log_l.delete();
    send_ramp(0, 16); drain();
    check_ramp("after_clr_drop");

    // asynchronous reset mid-frame with a pooled pixel pending
    rdy_mode = 0;
    send_ramp(0, 6);
    @(posedge clk); #1;
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_valid", 32'(out_valid), 32'd0);
    check("async_rst_last", 32'(out_last), 32'd0);
    check("async_rst_done", 32'(frame_done), 32'd0);
    model_reset();
    @(posedge clk); #1 rst = 1'b0; rdy_mode = 1;
    log_d.delete(); log_l.delete();
    send_ramp(0, 16); drain();
    check_ramp("after_rst");

    // random frames with random gaps and random downstream stalls
    rdy_mode = 2;
    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < W * H; i++) begin
        if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
        send(rnd_pix());
      end
    end
    drain();
    rdy_mode = 1;

    // two 32x32 frames back to back on the wide instance
    bmr = 0; bmc = 0;
    for (int i = 0; i < 2 * BW * BH; i++) begin
      d = rnd_pix();
      b_in_valid = 1'b1; b_in_data = d;
      @(negedge clk);
      if (b_in_ready) begin
        bpix[bmr][bmc] = relu(d);
        if (bmr % 2 == 1 && bmc % 2 == 1)
          bq.push_back({(bmr == BH-1 && bmc == BW-1),
                        max4(bpix[bmr-1][bmc-1], bpix[bmr-1][bmc], bpix[bmr][bmc-1], bpix[bmr][bmc])});
        if (bmc == BW-1) begin bmc = 0; bmr = (bmr == BH-1) ? 0 : bmr + 1; end
        else bmc++;
      end else begin
        nchk++; nfail++;
        $display("FAIL b_in_ready: got 0 required 1 at pixel %0d", i);
      end
      @(posedge clk); #1;
    end
    b_in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("b_total", b_nout, 512);
    check("b_pending", bq.size(), 0);
    check("b_last_count", b_lastpos.size(), 2);
    if (b_lastpos.size() == 2) begin
      check("b_last_pos0", b_lastpos[0], 256);
      check("b_last_pos1", b_lastpos[1], 512);
    end

    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end

endmodule
